stage1_pc_incrementer: RTL and testbench

Stage-1 (fetch) program-counter unit of the JALA CPU datapath. Holds the 16-bit PC and, on each rising clock edge while writes are enabled, loads one of three next-PC values: the sequential increment (PC + 1), a relative branch target (PC + sign-extended offset), or an absolute jump target from register value A. The PC output addresses instruction memory. The control inputs come from the control unit; the offset comes from the sign extender.

---
 rtl/stage1_pc_incrementer_if.sv | 28 ++
 rtl/stage1_pc_incrementer.sv | 42 ++++
 tb/tb_stage1_pc_incrementer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stage1_pc_incrementer_if.sv
// Control/data bundle between the control unit and the stage-1 PC register.
// The control unit drives the master side; the PC unit is the slave.
interface stage1_pc_incrementer_if;
    logic        PCWrite;
    logic        PCSource;
    logic        PCAdd;
    logic [15:0] PCAddFromSE;
    logic [15:0] PCSourceFromValA;
    logic [15:0] PC;

    modport master (
        output PCWrite,
        output PCSource,
        output PCAdd,
        output PCAddFromSE,
        output PCSourceFromValA,
        input  PC
    );

    modport slave (
        input  PCWrite,
        input  PCSource,
        input  PCAdd,
        input  PCAddFromSE,
        input  PCSourceFromValA,
        output PC
    );
endinterface

// File: rtl/stage1_pc_incrementer.sv
// Stage-1 program counter: jump / relative branch / increment, 16-bit wrapping.
// Optional feature macro PC_WRITE_GATING_EN: when defined, PCWrite gates PC updates.
module stage1_pc_incrementer (
    input  logic                    CLK,
    input  logic                    RST_N,
    stage1_pc_incrementer_if.slave  bus
);

    logic [15:0] pc_q;
    logic [15:0] next_pc;
    logic        update_en;

    // Jump beats branch; branch is relative to the current PC, not PC + 1.
    always_comb begin
        next_pc = pc_q + 16'd1;
        if (bus.PCSource) begin
            next_pc = bus.PCSourceFromValA;
        end else if (bus.PCAdd) begin
            next_pc = pc_q + bus.PCAddFromSE;
        end
    end

`ifdef PC_WRITE_GATING_EN
    assign update_en = bus.PCWrite;
`else
    // Port kept so instantiations are identical in both builds.
    logic unused_pc_write;
    assign unused_pc_write = bus.PCWrite;
    assign update_en       = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q <= 16'h0000;
        end else if (update_en) begin
            pc_q <= next_pc;
        end
    end

    assign bus.PC = pc_q;

endmodule

// File: tb/tb_stage1_pc_incrementer.sv
// Randomized and directed checks of stage1_pc_incrementer against a next-PC model.
module tb_stage1_pc_incrementer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   model_pc;

`ifdef PC_WRITE_GATING_EN
    localparam bit GATING = 1'b1;
`else
    localparam bit GATING = 1'b0;
`endif

    stage1_pc_incrementer_if bus ();

    stage1_pc_incrementer dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Reference: the specification's selection rules in plain integer arithmetic.
    function automatic int nextModel(input int pc, input bit wr, input bit src, input bit add,
                                     input int off, input int vala);
        if (GATING && !wr) return pc;
        if (src)           return vala;
        if (add)           return (pc + off) % 65536;
        return (pc + 1) % 65536;
    endfunction

    task automatic applyStimulus(input string tag, input bit wr, input bit src, input bit add,
                                 input logic [15:0] off, input logic [15:0] vala);
        bus.PCWrite          = wr;
        bus.PCSource         = src;
        bus.PCAdd            = add;
        bus.PCAddFromSE      = off;
        bus.PCSourceFromValA = vala;
        model_pc = nextModel(model_pc, wr, src, add, int'(off), int'(vala));
        @(posedge clk);
        #1;
        checkOutput(tag, bus.PC, model_pc[15:0]);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_pc = 0;
        rst_n    = 1'b0;
        bus.PCWrite          = 1'b1;
        bus.PCSource         = 1'b0;
        bus.PCAdd            = 1'b0;
        bus.PCAddFromSE      = 16'h0000;
        bus.PCSourceFromValA = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hold", bus.PC, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 1; k <= 33; k++) begin
            applyStimulus("increment", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            checkOutput("increment_k", bus.PC, 16'(k));
        end

        for (int i = 1; i <= 5; i++) begin
            applyStimulus("branch", 1'b1, 1'b0, 1'b1, 16'd255, 16'h0000);
            checkOutput("branch_const", bus.PC, 16'(33 + 255 * i));
        end

        applyStimulus("jump_priority", 1'b1, 1'b1, 1'b1, 16'd255, 16'd302);
        checkOutput("jump_const", bus.PC, 16'd302);

        for (int i = 1; i <= 3; i++) begin
            applyStimulus("hold_incr", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            checkOutput("hold_const", bus.PC, GATING ? 16'd302 : 16'(302 + i));
        end
        applyStimulus("hold_jump", 1'b0, 1'b1, 1'b1, 16'h0010, 16'hABCD);

        applyStimulus("jump_ffff", 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF);
        applyStimulus("wrap_incr", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("wrap_const", bus.PC, 16'h0000);
        applyStimulus("jump_5", 1'b1, 1'b1, 1'b0, 16'h0000, 16'd5);
        applyStimulus("wrap_branch", 1'b1, 1'b0, 1'b1, 16'hFFFE, 16'h0000);
        checkOutput("neg_branch_const", bus.PC, 16'd3);

        applyStimulus("jump_302", 1'b1, 1'b1, 1'b0, 16'h0000, 16'd302);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkOutput("async_reset", bus.PC, 16'h0000);
        model_pc = 0;
        #1 rst_n = 1'b1;
        applyStimulus("post_reset_incr", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("post_reset_const", bus.PC, 16'd1);

        for (int n = 0; n < 300; n++) begin
            applyStimulus("random",
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 1) == 1,
                          16'($urandom),
                          16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
